// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 2-to-4 decoder (select a1/a0, enable e).
// Optional grant-event counter output gnt_cnt is enabled by defining DECARB_GRANT_CNT_EN.
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       a1,
    output logic       a0,
    output logic       e,
    output logic       busy
`ifdef DECARB_GRANT_CNT_EN
    ,
    output logic [7:0] gnt_cnt
`endif
);

    localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e     state_q;
    logic [1:0] last_q;
    logic [7:0] hold_cnt_q;

    logic [3:0] cand;
    logic       found;
    logic [1:0] win;
    logic       owner_req;
    logic       timeout;
    logic       take;

    // The owner is masked out so handovers and rotations always move to someone else.
    assign cand = req & ~gnt;

    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        win   = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign owner_req = |(req & gnt);
    assign timeout   = (MaxHold != 8'd0) && (hold_cnt_q >= MaxHold);

    // Release takes precedence over timeout; both resolve to a new grant if anyone else waits.
    always_comb begin
        take = 1'b0;
        if (state_q == StIdle) begin
            take = found;
        end else begin
            take = found && (!owner_req || timeout);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt        <= 4'b0000;
            a1         <= 1'b0;
            a0         <= 1'b0;
            e          <= 1'b0;
            busy       <= 1'b0;
            last_q     <= 2'd3;
            hold_cnt_q <= 8'd0;
        end else if (take) begin
            state_q    <= StGrant;
            gnt        <= 4'b0001 << win;
            a1         <= win[1];
            a0         <= win[0];
            e          <= 1'b1;
            busy       <= 1'b1;
            last_q     <= win;
            hold_cnt_q <= 8'd1;
        end else if (state_q == StGrant && !owner_req) begin
            // a1/a0 keep the last owner's index while idle.
            state_q    <= StIdle;
            gnt        <= 4'b0000;
            e          <= 1'b0;
            busy       <= 1'b0;
            hold_cnt_q <= 8'd0;
        end else if (state_q == StGrant && hold_cnt_q != 8'hff) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
        end
    end

`ifdef DECARB_GRANT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_cnt <= 8'd0;
        end else if (take && gnt_cnt != 8'hff) begin
            gnt_cnt <= gnt_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Scoreboard bench for decoder_rr_arbiter: stimulus pushes model predictions, a monitor pops and
// compares after every rising edge.
module tb_decoder_rr_arbiter;

    localparam int unsigned MAXH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       a1, a0, e, busy;
`ifdef DECARB_GRANT_CNT_EN
    logic [7:0] gnt_cnt;
`endif

    always #5 clk = ~clk;

    decoder_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .a1    (a1),
        .a0    (a0),
        .e     (e),
        .busy  (busy)
`ifdef DECARB_GRANT_CNT_EN
        ,
        .gnt_cnt (gnt_cnt)
`endif
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       e;
        logic       busy;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   active = 1'b0;

    // Reference model state: owner = -1 means nobody holds the decoder.
    int m_owner = -1;
    int m_last  = 3;
    int m_hold  = 0;
    int m_sel   = 0;
    int m_cnt   = 0;

    function automatic int first_from(int start, logic [3:0] r, int skip);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (i != skip && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_grant(input int n);
        m_owner = n;
        m_last  = n;
        m_sel   = n;
        m_hold  = 1;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic step(input logic [3:0] r, input logic rn);
        int   nxt;
        exp_t x;
        @(negedge clk);
        req   = r;
        rst_n = rn;
        if (!rn) begin
            m_owner = -1; m_last = 3; m_hold = 0; m_sel = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            nxt = first_from((m_last + 1) % 4, r, -1);
            if (nxt >= 0) model_grant(nxt);
        end else begin
            nxt = first_from((m_owner + 1) % 4, r, m_owner);
            if (!r[m_owner]) begin
                if (nxt >= 0) model_grant(nxt);
                else begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end else if (MAXH != 0 && m_hold >= int'(MAXH) && nxt >= 0) begin
                model_grant(nxt);
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end
        x.gnt  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        x.sel  = 2'(m_sel);
        x.e    = (m_owner >= 0);
        x.busy = (m_owner >= 0);
        x.cnt  = 8'(m_cnt);
        exp_q.push_back(x);
        active = 1'b1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (active) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue_empty at %0t: got 0 entries expected >=1", $time);
            end else begin
                x = exp_q.pop_front();
                chk("gnt", {4'b0, gnt}, {4'b0, x.gnt});
                chk("a1a0", {6'b0, a1, a0}, {6'b0, x.sel});
                chk("e", {7'b0, e}, {7'b0, x.e});
                chk("busy", {7'b0, busy}, {7'b0, x.busy});
`ifdef DECARB_GRANT_CNT_EN
                chk("gnt_cnt", gnt_cnt, x.cnt);
`endif
            end
        end
    end

    initial begin
        logic [3:0] r;
        // Reset with everyone requesting, then release: requester 0 wins first.
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b1);
        // Handover without a gap, then wrap 3 -> 0.
        step(4'b1100, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b0001, 1'b1);
        // Forced rotation between 0 and 1.
        repeat (12) step(4'b0011, 1'b1);
        // Lone holder runs past the hold limit, then releases to idle.
        repeat (20) step(4'b1000, 1'b1);
        repeat (2) step(4'b0000, 1'b1);
        // Reset mid-grant, then requester 0 wins again.
        repeat (3) step(4'b0100, 1'b1);
        step(4'b0100, 1'b0);
        repeat (3) step(4'b1111, 1'b1);
        // Per-cycle handovers drive the grant counter into saturation.
        for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 4'b0010 : 4'b0001, 1'b1);
        // Randomised traffic with occasional owner release and rare resets.
        r = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 7) == 0) r[m_owner] = 1'b0;
            step(r, ($urandom_range(0, 99) != 0));
        end
        step(4'b0000, 1'b1);
        @(posedge clk);
        #2;
        active = 1'b0;
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
